wb_port_arbiter: RTL
====================

# wb_port_arbiter

Writeback-port arbiter for the core's single register-file write port. Up to eight result producers (ALU, load unit, multiplier, divider, CSR, PC+4, etc.) request the port. The arbiter picks one per cycle and drives the select of the 8:1 result multiplexer. It registers the selected data together with its destination register into a one-entry writeback stage that holds while the register file stalls.

## Interface
Parameters:
- BIT_WIDTH, 32, data width of each source and of the writeback data.
- REG_ADDR_W, 5, destination register index width.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-high.
- req_valid  in  8  per-source request; bit i = source i has a result.
- req_rd  in  8*REG_ADDR_W  per-source destination; source i at bits [i*REG_ADDR_W +: REG_ADDR_W].
- req_ready  out  8  one-hot grant; transfer from source i completes when req_valid[i] & req_ready[i].
- mux_sel  out  3  select driven to the 8:1 result mux; equals the granted index.
- mux_y  in  BIT_WIDTH  result mux output, i.e. data of source mux_sel, same cycle.
- stall  in  1  register file cannot accept a write this cycle.
- flush  in  1  discard the pending writeback and grant nothing this cycle.
- wb_en  out  1  register-file write enable.
- wb_rd  out  REG_ADDR_W  write address.
- wb_data  out  BIT_WIDTH  write data.

## Operation
- Slot state: wb_en marks the writeback register as occupied.
- `slot_free = !wb_en | !stall`. The slot is empty, or it drains this cycle.
- `grant_ok = slot_free & !flush & !rst`.
- If grant_ok and any req_valid is set:
  - Pick index g by the configured policy.
  - Assert req_ready[g] only, with mux_sel = g.
  - Next edge: wb_rd <= req_rd[g], wb_data <= mux_y, wb_en <= (req_rd[g] != 0).
- Writes to x0 complete the handshake but produce wb_en=0. Nothing is written.
- If nothing is granted and the slot drains (wb_en & !stall), then wb_en <= 0.
- If wb_en & stall and there is no flush, wb_en, wb_rd and wb_data hold unchanged.
- flush: wb_en <= 0 next edge. req_ready is 0 during the flush cycle. The round-robin pointer is unchanged.
- With no grant, mux_sel holds its last value so the mux does not toggle.
- Round-robin pointer ptr (3 bits):
  - Search starts at ptr.
  - After a grant to g, ptr <= (g+1) mod 8. The wrap from 7 goes to 0.
  - ptr updates only on a completed handshake.
- Reset values: wb_en=0, wb_rd=0, wb_data=0, mux_sel=0, ptr=0. req_ready=0 while rst=1.
- Reset mid-operation drops the held writeback. Reset has priority over flush, and flush has priority over stall.

## Timing
- Request to write: request at cycle t, grant at t (combinational from req_valid, ptr, wb_en, stall), wb_en high at t+1. Latency is 1 cycle.
- Sustained throughput is one writeback per cycle while stall=0.
- stall asserted at t with wb_en=1: no grant at t, and the write is re-presented at t+1.
- stall falling at t: the write retires at t, and a new grant is allowed in cycle t.
- req_valid must stay high until granted. The arbiter never drops a waiting request except under rst.
- req_ready depends combinationally on req_valid. Sources must not derive req_valid from req_ready.

## Configuration
- WB_ARB_RR_EN defined: round-robin policy with the rotating pointer above. Any continuously requesting source is granted within 8 grants.
- WB_ARB_RR_EN undefined: fixed priority, lowest index wins (source 0 highest). The ptr register is not instantiated. All other behaviour is identical.

## Structure
- Package wb_arb_pkg holds:
  - NUM_SRC=8 and SEL_W=3.
  - Source index constants: SRC_ALU=0, SRC_LOAD=1, SRC_MUL=2, SRC_DIV=3, SRC_CSR=4, SRC_PC4=5, SRC_AUX0=6, SRC_AUX1=7.
  - A typedef for the source index.
- One sub-module, wb_arb_pick: combinational picker from an 8-bit request vector and a 3-bit start index to a one-hot grant, binary index and any-valid flag. It is instantiated with start=0 when WB_ARB_RR_EN is undefined.

## Test plan
- Single request: req_valid=8'h04, req_rd[2]=5'd7, mux_y=32'hDEADBEEF -> req_ready=8'h04 and mux_sel=2 at t; wb_en=1, wb_rd=7, wb_data=32'hDEADBEEF at t+1.
- Contention, WB_ARB_RR_EN defined: req_valid=8'hFF held 10 cycles from reset -> grant order 0,1,...,7,0,1; wrap 7->0 checked.
- Contention, WB_ARB_RR_EN undefined: req_valid=8'h92 held -> source 1 granted every cycle; sources 4 and 7 never granted.
- Stall: grant source 3 (rd=9, data 32'h1234), then stall=1 for 3 cycles with req_valid=8'h01 -> wb held at rd=9/32'h1234 and req_ready=0 for 3 cycles; after release, source 0 is granted the same cycle stall drops.
- x0 and flush:
  - Source 5 with rd=0 -> req_ready[5]=1 and wb_en stays 0.
  - A pending wb_en=1 with stall=1, then flush=1 -> wb_en=0 next cycle; no grant in the flush cycle; ptr unchanged.
- Reset mid-stall: wb_en=1 held by stall, then rst=1 for one cycle -> wb_en=0, wb_rd=0, wb_data=0, mux_sel=0; the first grant after reset goes to the lowest requesting index.

Source files
------------

// File: rtl/wb_arb_pkg.sv
// wb_arb_pkg: shared sizes, source indices and index type for the writeback-port arbiter
package wb_arb_pkg;
  localparam int NUM_SRC = 8;
  localparam int SEL_W = 3;
  typedef logic [SEL_W-1:0] src_idx_t;
  localparam src_idx_t SRC_ALU  = 3'd0;
  localparam src_idx_t SRC_LOAD = 3'd1;
  localparam src_idx_t SRC_MUL  = 3'd2;
  localparam src_idx_t SRC_DIV  = 3'd3;
  localparam src_idx_t SRC_CSR  = 3'd4;
  localparam src_idx_t SRC_PC4  = 3'd5;
  localparam src_idx_t SRC_AUX0 = 3'd6;
  localparam src_idx_t SRC_AUX1 = 3'd7;
endpackage

// File: rtl/wb_arb_pick.sv
// wb_arb_pick: first set request found searching upward (with wrap) from start
module wb_arb_pick
  import wb_arb_pkg::*;
(
  input  logic [NUM_SRC-1:0] req,
  input  src_idx_t           start,
  output logic [NUM_SRC-1:0] gnt,
  output src_idx_t           idx,
  output logic               any
);
  src_idx_t i;
  always_comb begin
    i = start;
    idx = '0;
    any = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      i = start + SEL_W'(k);
      if (!any && req[i]) begin
        any = 1'b1;
        idx = i;
      end
    end
    gnt = any ? (NUM_SRC'(1) << idx) : '0;
  end
endmodule

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: register-file write-port arbiter with a one-entry stallable writeback stage.
// WB_ARB_RR_EN selects round-robin arbitration; otherwise fixed priority, source 0 highest.
module wb_port_arbiter
  import wb_arb_pkg::*;
#(
  parameter int BIT_WIDTH = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_SRC-1:0]            req_valid,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] req_rd,
  output logic [NUM_SRC-1:0]            req_ready,
  output logic [SEL_W-1:0]              mux_sel,
  input  logic [BIT_WIDTH-1:0]          mux_y,
  input  logic                          stall,
  input  logic                          flush,
  output logic                          wb_en,
  output logic [REG_ADDR_W-1:0]         wb_rd,
  output logic [BIT_WIDTH-1:0]          wb_data
);
  logic [NUM_SRC-1:0] gnt;
  src_idx_t idx, start, sel_q;
  logic any, fire;
  logic [REG_ADDR_W-1:0] rd_g;
  wb_arb_pick u_pick (
    .req   (req_valid),
    .start (start),
    .gnt   (gnt),
    .idx   (idx),
    .any   (any)
  );
  assign fire = (!wb_en || !stall) && !flush && !rst && any;
  assign req_ready = fire ? gnt : '0;
  assign mux_sel = fire ? idx : sel_q;
  assign rd_g = req_rd[idx*REG_ADDR_W +: REG_ADDR_W];
`ifdef WB_ARB_RR_EN
  src_idx_t ptr;
  assign start = ptr;
  always_ff @(posedge clk) begin
    if (rst) ptr <= '0;
    else if (fire) ptr <= idx + 1'b1;
  end
`else
  assign start = '0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_en <= 1'b0;
      wb_rd <= '0;
      wb_data <= '0;
      sel_q <= '0;
    end else if (flush) begin
      wb_en <= 1'b0;
    end else if (fire) begin
      wb_en <= rd_g != '0;
      wb_rd <= rd_g;
      wb_data <= mux_y;
      sel_q <= idx;
    end else if (!stall) begin
      wb_en <= 1'b0;
    end
  end
endmodule
